// File: rtl/ysyx_22050019_pipe_ctrl_pkg.sv
// Purpose : shared types for the pipeline hazard/stall controller.
// Latency : n/a (types, constants and a pure decode function only).
// Backpr. : n/a.
package pipe_ctrl_pkg;

  // Controller FSM: normal flow, or holding the whole pipe for a multi-cycle LSU access.
  typedef enum logic {
    RUN      = 1'b0,
    LSU_WAIT = 1'b1
  } state_e;

  // Winning stall/flush cause, listed highest priority first after NONE.
  typedef enum logic [2:0] {
    CAUSE_NONE  = 3'd0,
    CAUSE_LSU   = 3'd1,
    CAUSE_REDIR = 3'd2,
    CAUSE_LDUSE = 3'd3,
    CAUSE_IFU   = 3'd4
  } cause_e;

  // Architectural zero register: never a real producer, so never a hazard.
  localparam logic [4:0] REG_X0 = 5'd0;

  // Full set of per-register pipeline controls.
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_stall;
  } ctrl_t;

  // Controls driven while reset is held: front end bubbled, nothing held.
  localparam ctrl_t CTRL_RESET = '{
    pc_stall: 1'b0, if_id_stall: 1'b0, if_id_flush: 1'b1, id_ex_stall: 1'b0,
    id_ex_flush: 1'b1, ex_mem_stall: 1'b0, mem_wb_stall: 1'b0
  };

  // Map the winning cause onto the pipeline controls.
  function automatic ctrl_t cause_ctrl(input cause_e cause);
    ctrl_t c;
    c = '0;
    case (cause)
      CAUSE_LSU: begin
        // Freeze everything up to and including MEM/WB so the access result is not lost.
        c.pc_stall     = 1'b1;
        c.if_id_stall  = 1'b1;
        c.id_ex_stall  = 1'b1;
        c.ex_mem_stall = 1'b1;
        c.mem_wb_stall = 1'b1;
      end
      CAUSE_REDIR: begin
        // Squash the two wrong-path instructions behind EX.
        c.if_id_flush = 1'b1;
        c.id_ex_flush = 1'b1;
      end
      CAUSE_LDUSE, CAUSE_IFU: begin
        // Hold the front end and inject a bubble into EX; the back end drains.
        c.pc_stall    = 1'b1;
        c.if_id_stall = 1'b1;
        c.id_ex_flush = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ysyx_22050019_hazard_det.sv
// Purpose : load-use hazard comparator between the load in EX and the sources of ID.
// Latency : purely combinational, same cycle.
// Backpr. : none; the result only feeds the controller's priority mux.
// Ports   : ex_is_load_i/ex_rd_i (EX producer), id_rs{1,2}_i/_ren_i (ID consumers), ld_use_o.
module ysyx_22050019_hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_is_load_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_rs1_ren_i,
  input  logic       id_rs2_ren_i,
  output logic       ld_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit  = id_rs1_ren_i && (id_rs1_i == ex_rd_i);
    rs2_hit  = id_rs2_ren_i && (id_rs2_i == ex_rd_i);
    // x0 is hardwired, so a load targeting it never produces data anyone waits for.
    ld_use_o = ex_is_load_i && (ex_rd_i != REG_X0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/ysyx_22050019_pipe_ctrl.sv
// Purpose : central stall/flush controller for the 5-stage pipe, with perf counters and LSU watchdog.
// Latency : controls are combinational from state and inputs; counters and hang_o update on the next edge.
// Backpr. : an outstanding LSU access freezes PC through MEM/WB until lsu_done_i; lower causes wait behind it.
// Ports   : clk, rst_n (sync, active-high); LSU/EX/ID/IFU hazard sources in;
//           per-register stall/flush out; hang_o, stall_cnt_o, flush_cnt_o.
module ysyx_22050019_pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lsu_req_i,
  input  logic             lsu_done_i,
  input  logic             ex_is_load_i,
  input  logic [4:0]       ex_rd_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_ren_i,
  input  logic             id_rs2_ren_i,
  input  logic             redirect_i,
  input  logic             ifu_busy_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_stall_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_stall_o,
  output logic             mem_wb_stall_o,
  output logic             hang_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int              WC_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             hang_q, hang_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic   ld_use;
  logic   lsu_wait;
  cause_e cause;
  ctrl_t  ctrl;

  ysyx_22050019_hazard_det u_hazard_det (
    .ex_is_load_i (ex_is_load_i),
    .ex_rd_i      (ex_rd_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_rs1_ren_i (id_rs1_ren_i),
    .id_rs2_ren_i (id_rs2_ren_i),
    .ld_use_o     (ld_use)
  );

  // Next state and LSU-wait detection. A req with same-cycle done never leaves RUN.
  always_comb begin
    state_d  = state_q;
    lsu_wait = 1'b0;
    case (state_q)
      RUN: begin
        lsu_wait = lsu_req_i && !lsu_done_i;
        if (lsu_wait) state_d = LSU_WAIT;
      end
      LSU_WAIT: begin
        // The done cycle is not a wait cycle: MEM/WB captures the result on this edge.
        lsu_wait = !lsu_done_i;
        if (lsu_done_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Priority select; only the highest active cause drives the controls.
  always_comb begin
    cause = CAUSE_NONE;
    if (lsu_wait)        cause = CAUSE_LSU;
    else if (redirect_i) cause = CAUSE_REDIR;
    else if (ld_use)     cause = CAUSE_LDUSE;
    else if (ifu_busy_i) cause = CAUSE_IFU;

    ctrl = rst_n ? CTRL_RESET : cause_ctrl(cause);
  end

  // Watchdog and performance counters.
  always_comb begin
    wait_cnt_d = '0;
    hang_d     = hang_q;
    if ((state_q == LSU_WAIT) && !lsu_done_i) begin
      // Saturate so the counter cannot wrap while a hung access persists.
      wait_cnt_d = (wait_cnt_q == WAIT_LAST) ? wait_cnt_q : wait_cnt_q + WC_W'(1);
      if (wait_cnt_q == WAIT_LAST) hang_d = 1'b1;
    end

    stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, ctrl.pc_stall};
    flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, (ctrl.if_id_flush | ctrl.id_ex_flush)};
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      hang_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      hang_q      <= hang_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_stall_o     = ctrl.pc_stall;
  assign if_id_stall_o  = ctrl.if_id_stall;
  assign if_id_flush_o  = ctrl.if_id_flush;
  assign id_ex_stall_o  = ctrl.id_ex_stall;
  assign id_ex_flush_o  = ctrl.id_ex_flush;
  assign ex_mem_stall_o = ctrl.ex_mem_stall;
  assign mem_wb_stall_o = ctrl.mem_wb_stall;
  assign hang_o         = hang_q;
  assign stall_cnt_o    = stall_cnt_q;
  assign flush_cnt_o    = flush_cnt_q;

endmodule

// File: tb/tb_ysyx_22050019_pipe_ctrl.sv
// Purpose : directed self-checking bench for the pipeline stall/flush controller.
// Latency : controls checked mid-cycle, counters and hang_o checked 1 time unit after each edge.
// Backpr. : n/a.
module tb_ysyx_22050019_pipe_ctrl;

  localparam int CNT_W = 64;

  // Control vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_stall}
  localparam logic [6:0] C_IDLE  = 7'b000_0000;
  localparam logic [6:0] C_RST   = 7'b001_0100;
  localparam logic [6:0] C_LSU   = 7'b110_1011;
  localparam logic [6:0] C_REDIR = 7'b001_0100;
  localparam logic [6:0] C_FRONT = 7'b110_0100;

  logic             clk;
  logic             rst_n;
  logic             lsu_req_i, lsu_done_i, ex_is_load_i;
  logic [4:0]       ex_rd_i, id_rs1_i, id_rs2_i;
  logic             id_rs1_ren_i, id_rs2_ren_i, redirect_i, ifu_busy_i;
  logic             pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o;
  logic             id_ex_flush_o, ex_mem_stall_o, mem_wb_stall_o, hang_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  int               n_vec;
  int               n_err;
  logic [CNT_W-1:0] exp_stall;
  logic [CNT_W-1:0] exp_flush;
  logic             exp_hang;

  ysyx_22050019_pipe_ctrl #(.TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lsu_req_i      (lsu_req_i),
    .lsu_done_i     (lsu_done_i),
    .ex_is_load_i   (ex_is_load_i),
    .ex_rd_i        (ex_rd_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .id_rs1_ren_i   (id_rs1_ren_i),
    .id_rs2_ren_i   (id_rs2_ren_i),
    .redirect_i     (redirect_i),
    .ifu_busy_i     (ifu_busy_i),
    .pc_stall_o     (pc_stall_o),
    .if_id_stall_o  (if_id_stall_o),
    .if_id_flush_o  (if_id_flush_o),
    .id_ex_stall_o  (id_ex_stall_o),
    .id_ex_flush_o  (id_ex_flush_o),
    .ex_mem_stall_o (ex_mem_stall_o),
    .mem_wb_stall_o (mem_wb_stall_o),
    .hang_o         (hang_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    lsu_req_i    = 1'b0;
    lsu_done_i   = 1'b0;
    ex_is_load_i = 1'b0;
    ex_rd_i      = 5'd0;
    id_rs1_i     = 5'd0;
    id_rs2_i     = 5'd0;
    id_rs1_ren_i = 1'b0;
    id_rs2_ren_i = 1'b0;
    redirect_i   = 1'b0;
    ifu_busy_i   = 1'b0;
  endtask

  // One cycle: check the combinational controls for the inputs already applied,
  // clock, then advance the counter model from the expected controls and check state.
  task automatic cyc(input string tag, input logic [6:0] exp_ctrl);
    logic [6:0] got_ctrl;
    #1;
    got_ctrl = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
                id_ex_flush_o, ex_mem_stall_o, mem_wb_stall_o};
    chk_eq({tag, ".ctrl"}, 64'(got_ctrl), 64'(exp_ctrl));
    @(posedge clk);
    #1;
    if (rst_n) begin
      exp_stall = '0;
      exp_flush = '0;
      exp_hang  = 1'b0;
    end else begin
      exp_stall = exp_stall + 64'(exp_ctrl[6]);
      exp_flush = exp_flush + 64'(exp_ctrl[4] | exp_ctrl[2]);
    end
    chk_eq({tag, ".stall_cnt"}, stall_cnt_o, exp_stall);
    chk_eq({tag, ".flush_cnt"}, flush_cnt_o, exp_flush);
    chk_eq({tag, ".hang"}, 64'(hang_o), 64'(exp_hang));
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    exp_stall = '0;
    exp_flush = '0;
    exp_hang  = 1'b0;
    rst_n     = 1'b1;
    idle_inputs();

    // 1. reset for 3 cycles, then release idle
    for (int i = 0; i < 3; i++) cyc("reset", C_RST);
    rst_n = 1'b0;
    cyc("idle", C_IDLE);

    // 2. LSU access, done 4 cycles after request
    lsu_req_i = 1'b1;
    for (int i = 0; i < 4; i++) cyc("lsu_wait", C_LSU);
    lsu_done_i = 1'b1;
    cyc("lsu_done", C_IDLE);
    chk_eq("lsu_stall_total", stall_cnt_o, 64'd4);
    idle_inputs();
    cyc("lsu_after", C_IDLE);

    // 3. load-use on rs2, then rd=x0, then rs1 path
    ex_is_load_i = 1'b1; ex_rd_i = 5'd5; id_rs2_ren_i = 1'b1; id_rs2_i = 5'd5;
    cyc("lduse_rs2", C_FRONT);
    ex_rd_i = 5'd0; id_rs2_i = 5'd0;
    cyc("lduse_x0", C_IDLE);
    idle_inputs();
    ex_is_load_i = 1'b1; ex_rd_i = 5'd7; id_rs1_ren_i = 1'b1; id_rs1_i = 5'd7;
    cyc("lduse_rs1", C_FRONT);
    id_rs1_ren_i = 1'b0;
    cyc("lduse_noren", C_IDLE);
    id_rs1_ren_i = 1'b1; ex_is_load_i = 1'b0;
    cyc("lduse_notload", C_IDLE);

    // 4. redirect beats load-use; redirect held through an LSU wait
    ex_is_load_i = 1'b1; redirect_i = 1'b1;
    cyc("redir_over_lduse", C_REDIR);
    idle_inputs();
    lsu_req_i = 1'b1; redirect_i = 1'b1;
    cyc("redir_in_lsu0", C_LSU);
    cyc("redir_in_lsu1", C_LSU);
    lsu_done_i = 1'b1;
    cyc("redir_after_lsu", C_REDIR);
    idle_inputs();

    // IFU busy alone, and behind redirect
    ifu_busy_i = 1'b1;
    cyc("ifu_busy", C_FRONT);
    redirect_i = 1'b1;
    cyc("redir_over_ifu", C_REDIR);
    idle_inputs();

    // 6. zero-stall access: req and done together in RUN
    lsu_req_i = 1'b1; lsu_done_i = 1'b1;
    cyc("zero_stall", C_IDLE);
    lsu_req_i = 1'b0; lsu_done_i = 1'b0;
    cyc("zero_stall_run", C_IDLE);

    // 5. watchdog with TIMEOUT=8: entry cycle, then 8 LSU_WAIT cycles to raise hang
    lsu_req_i = 1'b1;
    cyc("wd_entry", C_LSU);
    for (int k = 1; k <= 10; k++) begin
      if (k == 8) exp_hang = 1'b1;
      cyc("wd_wait", C_LSU);
    end
    // reset mid-wait clears hang and counters; late done afterwards is ignored
    rst_n = 1'b1;
    cyc("wd_reset", C_RST);
    rst_n = 1'b0;
    lsu_req_i = 1'b0; lsu_done_i = 1'b1;
    cyc("late_done", C_IDLE);
    lsu_done_i = 1'b0;
    cyc("post_reset_run", C_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
